// File: rtl/barrett_reduce_pipe.sv
// 3-stage Barrett reduction mod q=3329: emits total_sum = r - q in [-q, q) for a 24-bit product.
// Optional out_range_err flag (in_a >= q*q) enabled by defining BARRETT_RANGE_CHECK_EN.
module barrett_reduce_pipe #(
    parameter int TAG_W     = 8,
    parameter int Q         = 3329,
    parameter int BARRETT_M = 20158,
    parameter int BARRETT_K = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      out_total_sum,
`ifdef BARRETT_RANGE_CHECK_EN
    output logic             out_range_err,
`endif
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [14:0] M_C   = 15'(BARRETT_M);
    localparam logic [11:0] Q_C   = 12'(Q);
    localparam logic [23:0] QSQ_C = 24'(Q * Q);

    logic             w_adv;
    logic             w_acc;
    logic [12:0]      w_t;
    logic [24:0]      w_tq;
    logic [13:0]      w_r;
    logic [13:0]      w_sum;
    logic             w_unused;

    logic [3:1]       r_vld_pipe;
    logic [38:0]      r_p1;
    logic [13:0]      r_a1;
    logic [13:0]      r_a2;
    logic [13:0]      r_tq2;
    logic [12:0]      r_sum3;
    logic [TAG_W-1:0] r_tag1;
    logic [TAG_W-1:0] r_tag2;
    logic [TAG_W-1:0] r_tag3;

    // Whole pipe freezes on output stall; bubbles are not squeezed out.
    assign w_adv = ~r_vld_pipe[3] | out_ready;
    assign w_acc = in_valid & w_adv;

    assign w_t   = r_p1[BARRETT_K +: 13];
    assign w_tq  = 25'(w_t) * 25'(Q_C);
    // r < 1.25q fits in 14 bits, so only the low bits of a and t*q matter.
    assign w_r   = r_a2 - r_tq2;
    assign w_sum = w_r - 14'(Q_C);

    assign w_unused = &{1'b0, r_p1[BARRETT_K-1:0], w_tq[24:14], w_sum[13]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_p1       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_tq2      <= '0;
            r_sum3     <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
            r_tag3     <= '0;
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[2:1], w_acc};
            r_p1       <= 39'(in_a) * 39'(M_C);
            r_a1       <= in_a[13:0];
            r_tag1     <= in_tag;
            r_a2       <= r_a1;
            r_tq2      <= w_tq[13:0];
            r_tag2     <= r_tag1;
            r_sum3     <= w_sum[12:0];
            r_tag3     <= r_tag2;
        end
    end

`ifdef BARRETT_RANGE_CHECK_EN
    logic r_re1;
    logic r_re2;
    logic r_re3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_re1 <= 1'b0;
            r_re2 <= 1'b0;
            r_re3 <= 1'b0;
        end else if (w_adv) begin
            r_re1 <= (in_a >= QSQ_C);
            r_re2 <= r_re1;
            r_re3 <= r_re2;
        end
    end

    assign out_range_err = r_re3;
`endif

    assign in_ready      = w_adv;
    assign out_valid     = r_vld_pipe[3];
    assign out_total_sum = r_sum3;
    assign out_tag       = r_tag3;
endmodule

// File: doc/barrett_reduce_pipe.md
Name: barrett_reduce_pipe

Overview:
- 3-stage pipelined Barrett reduction for Kyber, q = 3329 (0xD01). Sits directly upstream of the conditional-add stage.
- Takes a 24-bit product (e.g. 12x12 coefficient x twiddle) and emits a 13-bit two's-complement total_sum = r - q, with r = a mod q or a mod q + q, so total_sum lies in [-q, q).
- The downstream conditional add (add q if bit 12 set) then yields the canonical 12-bit result in [0, q).
- Valid/ready handshake on both sides; a sideband tag travels with each sample.

Parameters:
- TAG_W, 8, width of the sideband tag (coefficient index) carried alongside each sample.
- Q, 3329, modulus. Fixed for Kyber; other values are not supported.
- BARRETT_M, 20158, floor(2^26 / Q).
- BARRETT_K, 26, Barrett shift.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_a  input  24  unsigned operand, 0 .. 2^24-1.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  total_sum valid.
- out_ready  input  1  downstream accepts this cycle.
- out_total_sum  output  13  r - q, two's complement, range [-3329, 3328].
- out_tag  output  TAG_W  tag aligned with out_total_sum.

Behaviour:
- Reset (async assert, sync deassert at the clk edge): all stage valids = 0, out_valid = 0, out_total_sum = 0, out_tag = 0. in_ready = 1 from the first cycle after reset.
- Global advance: adv = ~s3_valid | out_ready. in_ready = adv. All stage registers load only when adv = 1. A transfer occurs when in_valid & in_ready.
- S1 (register): a1 = in_a; p1 = in_a * BARRETT_M (39 bits); v1 = in_valid & in_ready; tag1 = in_tag.
- S2 (register): t = p1 >> 26 (13 bits, max 5039); tq = t * Q (25 bits); a2 = a1; v2 = v1.
- S3 (register, drives the outputs): r = a2 - tq, computed at 14 bits. The Barrett error bound guarantees 0 <= r < 1.25q for any 24-bit a. out_total_sum = r - Q, truncated to 13 bits, which is exact. out_valid = v2.
- Latency: 3 cycles from accept to out_valid when out_ready is held high. Throughput: 1 sample per cycle.
- Backpressure: when out_valid = 1 and out_ready = 0, the whole pipe freezes and all outputs hold stable. Bubbles in S1/S2 are not collapsed while frozen, so the pipe holds at most 3 samples.
- Simultaneous accept and emit with out_ready = 1: the pipe shifts by one; no sample is lost or duplicated.
- Ordering: strictly in order. Tags stay aligned with their data.
- Data registers of stages with valid = 0 may load any value. Only valid-qualified outputs are checked.
- Reset mid-operation: all in-flight samples are discarded and the block behaves as at power-up.

Optional Feature:
- Macro: BARRETT_RANGE_CHECK_EN.
- Defined: adds output port out_range_err (1 bit, reset 0), pipelined alongside the data. It is set for a sample whose in_a >= Q*Q (11082241), i.e. not a valid product of two reduced coefficients. The arithmetic result is still produced correctly.
- Undefined: the port and its logic are absent; the interface is as listed above.

Test Plan:
- Reset, then in_a = 0 with out_ready = 1 -> out_total_sum = 0x12FF (-3329) at cycle +3.
- in_a = 3329 -> out_total_sum = 0; in_a = 11075584 (3328*3328) -> 1; in_a = 16777215 -> 0x1C4F (-945). With BARRETT_RANGE_CHECK_EN, out_range_err = 1 for the last one only.
- Streaming: 1000 random in_a back-to-back, out_ready = 1 -> one result per cycle. Each (result + q if negative) equals in_a mod 3329; tags come out in order.
- Backpressure: out_ready = 0, 5 samples offered with tags 1..5 -> 3 accepted, then in_ready = 0 and outputs stable. Raise out_ready -> tags 1..5 emerge in order, none lost.
- Random out_ready toggling (50%) and random in_valid -> scoreboard match, no duplicates, out_valid never drops while out_ready = 0.
- Assert rst with 3 samples in flight -> out_valid = 0 immediately (async). After release, a fresh sample a = 3329 yields 0 with 3-cycle latency.
